// File: rtl/sal_ddr_params_pkg.sv
// Shared DDR write-PHY parameters and the pin-state encoding.
package sal_ddr_params_pkg;

    localparam int unsigned DFLT_DQ_WIDTH = 64;
    localparam int unsigned DFLT_DM_WIDTH = DFLT_DQ_WIDTH / 8;
    localparam int unsigned BEAT_CNT_W    = 16;

    // What the DQ/DQS pins show in the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        POST = 2'd3
    } wr_phy_state_t;

endpackage

// File: rtl/DFI_WR_IF.sv
// DFI write-data channel: controller drives SRC, PHY consumes DST.
interface DFI_WR_IF #(
    parameter int unsigned DQ_WIDTH = 64,
    parameter int unsigned DM_WIDTH = DQ_WIDTH / 8
) ();

    logic                    wrdata_en;
    logic [2*DQ_WIDTH-1:0]   wrdata;
    logic [2*DM_WIDTH-1:0]   wrdata_mask;

    modport SRC (output wrdata_en, output wrdata, output wrdata_mask);
    modport DST (input  wrdata_en, input  wrdata, input  wrdata_mask);

endinterface

// File: rtl/sal_wr_phy_stage.sv
// Two-deep data/mask pipeline; the second stage doubles as the pin register.
module sal_wr_phy_stage #(
    parameter int unsigned DW = 128,
    parameter int unsigned MW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_v,
    input  logic [DW-1:0] in_d,
    input  logic [MW-1:0] in_m,
    input  logic          drive,
    output logic          s1_v,
    output logic [DW-1:0] s2_d,
    output logic [MW-1:0] s2_m
);

    logic [DW-1:0] s1_d;
    logic [MW-1:0] s1_m;

    // First stage captures the DFI word unconditionally every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            s1_m <= '0;
        end else begin
            s1_v <= in_v;
            s1_d <= in_d;
            s1_m <= in_m;
        end
    end

    // Second stage loads valid words and is zeroed whenever the pins leave DATA.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_d <= '0;
            s2_m <= '0;
        end else if (!drive) begin
            s2_d <= '0;
            s2_m <= '0;
        end else if (s1_v) begin
            s2_d <= s1_d;
            s2_m <= s1_m;
        end
    end

endmodule

// File: rtl/sal_dfi_wr_phy.sv
// DDR2 write-side PHY datapath: DFI write data to ODDR/tristate pad values,
// with DQS preamble/postamble generation, burst merging and beat statistics.
module sal_dfi_wr_phy
    import sal_ddr_params_pkg::*;
#(
    parameter int unsigned DQ_WIDTH = DFLT_DQ_WIDTH,
    parameter int unsigned DM_WIDTH = DQ_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    DFI_WR_IF.DST                 dfi_wr_if,
    output logic [DQ_WIDTH-1:0]   dq_rise_o,
    output logic [DQ_WIDTH-1:0]   dq_fall_o,
    output logic [DM_WIDTH-1:0]   dm_rise_o,
    output logic [DM_WIDTH-1:0]   dm_fall_o,
    output logic                  dq_oe_o,
    output logic                  dqs_rise_o,
    output logic                  dqs_fall_o,
    output logic                  dqs_oe_o,
    output logic                  wr_busy_o,
    output logic                  burst_err_o,
    output logic [BEAT_CNT_W-1:0] wr_beats_o
);

    localparam int unsigned DW = 2 * DQ_WIDTH;
    localparam int unsigned MW = 2 * DM_WIDTH;

    wr_phy_state_t state;
    wr_phy_state_t state_nx;

    logic          s1_v;
    logic [DW-1:0] s2_d;
    logic [MW-1:0] s2_m;
    logic          run_odd;
    logic          drive_c;
    logic          err_set_c;

    assign drive_c = (state_nx == DATA);

    sal_wr_phy_stage #(
        .DW (DW),
        .MW (MW)
    ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .in_v  (dfi_wr_if.wrdata_en),
        .in_d  (dfi_wr_if.wrdata),
        .in_m  (dfi_wr_if.wrdata_mask),
        .drive (drive_c),
        .s1_v  (s1_v),
        .s2_d  (s2_d),
        .s2_m  (s2_m)
    );

    // Next pin state; POST can re-enter DATA directly and so acts as a preamble.
    always_comb begin
        state_nx  = state;
        err_set_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (dfi_wr_if.wrdata_en) begin
                    state_nx = PRE;
                end else if (s1_v) begin
                    state_nx  = DATA;
                    err_set_c = 1'b1;
                end
            end
            PRE: begin
                state_nx = DATA;
            end
            DATA: begin
                if (!s1_v) begin
                    state_nx = POST;
                end
            end
            POST: begin
                if (s1_v) begin
                    state_nx = DATA;
                end else if (dfi_wr_if.wrdata_en) begin
                    state_nx = PRE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // The run that just closed must have been a whole number of BL4 bursts.
        if ((state == POST) && run_odd) begin
            err_set_c = 1'b1;
        end
    end

    // State, DQS/OE pin registers, run parity and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dqs_oe_o    <= 1'b0;
            dq_oe_o     <= 1'b0;
            dqs_rise_o  <= 1'b0;
            run_odd     <= 1'b0;
            burst_err_o <= 1'b0;
            wr_beats_o  <= '0;
        end else begin
            state      <= state_nx;
            dqs_oe_o   <= (state_nx != IDLE);
            dq_oe_o    <= drive_c;
            dqs_rise_o <= drive_c;
            if ((state != DATA) && drive_c) begin
                run_odd <= 1'b0;
            end else if (state == DATA) begin
                run_odd <= ~run_odd;
            end
            if (err_set_c) begin
                burst_err_o <= 1'b1;
            end
            if (drive_c) begin
                wr_beats_o <= wr_beats_o + BEAT_CNT_W'(1);
            end
        end
    end

    // DQS is high on the rising half and low on the falling half of every beat.
    assign dqs_fall_o = 1'b0;

    // Lane split: low half of the DFI word goes out on the rising edge.
    assign dq_rise_o = s2_d[DQ_WIDTH-1:0];
    assign dq_fall_o = s2_d[DW-1:DQ_WIDTH];
    assign dm_rise_o = s2_m[DM_WIDTH-1:0];
    assign dm_fall_o = s2_m[MW-1:DM_WIDTH];

    // Turnaround status: anything accepted, in flight or still on the pins.
    assign wr_busy_o = dfi_wr_if.wrdata_en | s1_v | (state != IDLE);

endmodule

// File: tb/tb_sal_dfi_wr_phy.sv
`timescale 1ns/1ps
module tb_sal_dfi_wr_phy;
    import sal_ddr_params_pkg::*;

    localparam int unsigned DQW = DFLT_DQ_WIDTH;
    localparam int unsigned DMW = DFLT_DM_WIDTH;
    localparam int unsigned DW  = 2 * DQW;
    localparam int unsigned MW  = 2 * DMW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    DFI_WR_IF #(.DQ_WIDTH(DQW), .DM_WIDTH(DMW)) dfi_if ();

    logic [DQW-1:0] dq_rise, dq_fall;
    logic [DMW-1:0] dm_rise, dm_fall;
    logic           dq_oe, dqs_rise, dqs_fall, dqs_oe, busy, berr;
    logic [15:0]    beats;

    sal_dfi_wr_phy #(.DQ_WIDTH(DQW), .DM_WIDTH(DMW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dfi_wr_if   (dfi_if),
        .dq_rise_o   (dq_rise),
        .dq_fall_o   (dq_fall),
        .dm_rise_o   (dm_rise),
        .dm_fall_o   (dm_fall),
        .dq_oe_o     (dq_oe),
        .dqs_rise_o  (dqs_rise),
        .dqs_fall_o  (dqs_fall),
        .dqs_oe_o    (dqs_oe),
        .wr_busy_o   (busy),
        .burst_err_o (berr),
        .wr_beats_o  (beats)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: enable/data history, pin phase derived from it.
    logic           h1, h2, h3;
    logic [DW-1:0]  dh1, dh2;
    logic [MW-1:0]  mh1, mh2;
    logic           e_pre, e_data, e_post;
    logic           prev_post, prev_data, m_err;
    logic [15:0]    m_beats;
    int             run;
    logic           started = 1'b0;

    int             cyc;
    logic           obs_dqs_oe [0:63];
    logic           obs_dq_oe  [0:63];
    logic           obs_err    [0:63];
    logic [15:0]    obs_beats  [0:63];
    logic [DQW-1:0] obs_dq_r   [0:63];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic en, input logic [DW-1:0] d, input logic [MW-1:0] m);
        if (!r) begin
            h1 = 0; h2 = 0; h3 = 0; dh1 = '0; dh2 = '0; mh1 = '0; mh2 = '0;
            e_pre = 0; e_data = 0; e_post = 0;
            prev_post = 0; prev_data = 0; m_err = 0; m_beats = '0; run = 0;
        end else begin
            // A postamble last cycle closed a run; BL4 runs must be even in length.
            if (prev_post && run[0]) m_err = 1;
            h3 = h2; h2 = h1; h1 = en;
            dh2 = dh1; dh1 = d; mh2 = mh1; mh1 = m;
            e_data = h2;
            e_post = h3 && !h2;
            e_pre  = h1 && !h2 && !e_post;
            if (e_data) begin
                run = prev_data ? run + 1 : 1;
                m_beats = m_beats + 16'd1;
            end
            prev_post = e_post;
            prev_data = e_data;
        end
    endtask

    task automatic check_pins();
        chk("dqs_oe",    128'(dqs_oe),   128'(e_pre | e_data | e_post));
        chk("dq_oe",     128'(dq_oe),    128'(e_data));
        chk("dqs_rise",  128'(dqs_rise), 128'(e_data));
        chk("dqs_fall",  128'(dqs_fall), 128'(1'b0));
        chk("dq_rise",   128'(dq_rise),  128'(e_data ? dh2[DQW-1:0]  : {DQW{1'b0}}));
        chk("dq_fall",   128'(dq_fall),  128'(e_data ? dh2[DW-1:DQW] : {DQW{1'b0}}));
        chk("dm_rise",   128'(dm_rise),  128'(e_data ? mh2[DMW-1:0]  : {DMW{1'b0}}));
        chk("dm_fall",   128'(dm_fall),  128'(e_data ? mh2[MW-1:DMW] : {DMW{1'b0}}));
        chk("wr_beats",  128'(beats),    128'(m_beats));
        chk("burst_err", 128'(berr),     128'(m_err));
    endtask

    // One clock: drive inputs, check busy, clock, check registered pins.
    task automatic cycle(input logic r, input logic en, input logic [DW-1:0] d, input logic [MW-1:0] m);
        rst_n = r;
        dfi_if.wrdata_en   = en;
        dfi_if.wrdata      = d;
        dfi_if.wrdata_mask = m;
        #1;
        if (started) chk("wr_busy", 128'(busy), 128'(en | h1 | e_pre | e_data | e_post));
        @(posedge clk);
        model_edge(r, en, d, m);
        started = 1'b1;
        #1;
        check_pins();
        cyc++;
        if (cyc < 64) begin
            obs_dqs_oe[cyc] = dqs_oe;
            obs_dq_oe[cyc]  = dq_oe;
            obs_err[cyc]    = berr;
            obs_beats[cyc]  = beats;
            obs_dq_r[cyc]   = dq_rise;
        end
    endtask

    function automatic logic [DW-1:0] word_d(input int i);
        logic [DW-1:0] w;
        for (int k = 0; k < int'(DW / 32); k++) w[k*32 +: 32] = 32'(i) ^ (32'hA5A5_0000 + 32'(k));
        return w;
    endfunction

    // Runs cycles 0..n-1: reset at 0-1 (and at rst_at), enable from pat.
    task automatic run_seq(input logic [63:0] pat, input int rst_at, input int n);
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            logic r;
            r = !((i < 2) || (i == rst_at));
            cycle(r, pat[i], word_d(i), MW'(i * 7 + 3));
        end
    endtask

    typedef struct {
        logic           en;
        logic [DW-1:0]  d;
        logic [MW-1:0]  m;
        logic           x_dqs_oe;
        logic           x_dq_oe;
        logic [DQW-1:0] x_dq_rise;
        logic [DQW-1:0] x_dq_fall;
        logic [DMW-1:0] x_dm_rise;
        logic [DMW-1:0] x_dm_fall;
        logic [15:0]    x_beats;
    } vec_t;

    vec_t tbl [0:19];

    initial begin
        logic [63:0] pat;
        int brem, grem;

        rst_n = 1'b0;
        dfi_if.wrdata_en = 1'b0;
        dfi_if.wrdata = '0;
        dfi_if.wrdata_mask = '0;

        // Single BL4 with lane/mask mapping: row i = inputs at cycle i, outputs at i+1.
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{default: '0};
            tbl[i].x_dqs_oe = (i >= 10) && (i <= 13);
            tbl[i].x_dq_oe  = (i == 11) || (i == 12);
            tbl[i].x_beats  = (i < 11) ? 16'd0 : ((i == 11) ? 16'd1 : 16'd2);
        end
        tbl[10].en = 1'b1;
        tbl[10].d  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111};
        tbl[10].m  = 16'h00F0;
        tbl[11].en = 1'b1;
        tbl[11].d  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        tbl[11].m  = 16'hA55A;
        tbl[11].x_dq_rise = 64'h1111_1111_1111_1111;
        tbl[11].x_dq_fall = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl[11].x_dm_rise = 8'hF0;
        tbl[11].x_dm_fall = 8'h00;
        tbl[12].x_dq_rise = 64'hFEDC_BA98_7654_3210;
        tbl[12].x_dq_fall = 64'h0123_4567_89AB_CDEF;
        tbl[12].x_dm_rise = 8'h5A;
        tbl[12].x_dm_fall = 8'hA5;

        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(i >= 2, tbl[i].en, tbl[i].d, tbl[i].m);
            chk("tbl_dqs_oe",  128'(dqs_oe),  128'(tbl[i].x_dqs_oe));
            chk("tbl_dq_oe",   128'(dq_oe),   128'(tbl[i].x_dq_oe));
            chk("tbl_dq_rise", 128'(dq_rise), 128'(tbl[i].x_dq_rise));
            chk("tbl_dq_fall", 128'(dq_fall), 128'(tbl[i].x_dq_fall));
            chk("tbl_dm_rise", 128'(dm_rise), 128'(tbl[i].x_dm_rise));
            chk("tbl_dm_fall", 128'(dm_fall), 128'(tbl[i].x_dm_fall));
            chk("tbl_beats",   128'(beats),   128'(tbl[i].x_beats));
            chk("tbl_err",     128'(berr),    128'(1'b0));
        end

        // Gap of one cycle: POST bridges straight back into DATA.
        pat = '0; pat[10] = 1; pat[11] = 1; pat[13] = 1; pat[14] = 1;
        run_seq(pat, -1, 24);
        for (int c = 11; c <= 17; c++) chk("gap1_dqs_oe_held", 128'(obs_dqs_oe[c]), 128'(1'b1));
        chk("gap1_post_dq_oe", 128'(obs_dq_oe[14]), 128'(1'b0));
        chk("gap1_data2",      128'(obs_dq_oe[15]), 128'(1'b1));
        chk("gap1_post2",      128'(obs_dq_oe[17]), 128'(1'b0));
        chk("gap1_idle",       128'(obs_dqs_oe[18]), 128'(1'b0));
        chk("gap1_beats",      128'(obs_beats[20]), 128'(16'd4));

        // Gap of two cycles: POST then PRE, DQS enable never drops.
        pat = '0; pat[10] = 1; pat[11] = 1; pat[14] = 1; pat[15] = 1;
        run_seq(pat, -1, 24);
        for (int c = 11; c <= 18; c++) chk("gap2_dqs_oe_held", 128'(obs_dqs_oe[c]), 128'(1'b1));
        chk("gap2_post", 128'(obs_dq_oe[14]), 128'(1'b0));
        chk("gap2_pre",  128'(obs_dq_oe[15]), 128'(1'b0));
        chk("gap2_d16",  128'(obs_dq_oe[16]), 128'(1'b1));
        chk("gap2_d17",  128'(obs_dq_oe[17]), 128'(1'b1));
        chk("gap2_idle", 128'(obs_dqs_oe[19]), 128'(1'b0));

        // Odd-length run: sticky error from cycle 16.
        pat = '0; pat[10] = 1; pat[11] = 1; pat[12] = 1;
        run_seq(pat, -1, 30);
        chk("odd_err_pre", 128'(obs_err[15]), 128'(1'b0));
        for (int c = 16; c < 31; c++) chk("odd_err_sticky", 128'(obs_err[c]), 128'(1'b1));

        // Reset mid-burst, then a clean BL4.
        pat = '0; pat[10] = 1; pat[11] = 1; pat[12] = 1; pat[20] = 1; pat[21] = 1;
        run_seq(pat, 12, 30);
        chk("rst_clears_err", 128'(obs_err[3]), 128'(1'b0));
        chk("rst_pre_data",   128'(obs_dq_oe[12]), 128'(1'b1));
        chk("rst_dqs_oe",     128'(obs_dqs_oe[13]), 128'(1'b0));
        chk("rst_dq_oe",      128'(obs_dq_oe[13]), 128'(1'b0));
        chk("rst_dq",         128'(obs_dq_r[13]), 128'(0));
        chk("rst_beats",      128'(obs_beats[13]), 128'(16'd0));
        for (int c = 21; c <= 24; c++) chk("rst_next_dqs_oe", 128'(obs_dqs_oe[c]), 128'(1'b1));
        chk("rst_next_dq_oe22", 128'(obs_dq_oe[22]), 128'(1'b1));
        chk("rst_next_idle",    128'(obs_dqs_oe[25]), 128'(1'b0));
        chk("rst_next_beats",   128'(obs_beats[25]), 128'(16'd2));
        chk("rst_next_err",     128'(obs_err[25]), 128'(1'b0));

        // Randomised bursts, gaps and occasional resets against the model.
        brem = 0;
        grem = 0;
        for (int i = 0; i < 4000; i++) begin
            logic en, r;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 249) != 0);
            if (brem == 0 && grem == 0) begin
                brem = 2 * int'($urandom_range(1, 4)) + (($urandom_range(0, 15) == 0) ? 1 : 0);
                grem = int'($urandom_range(0, 5));
            end
            if (brem > 0) begin
                en = 1'b1;
                brem--;
            end else begin
                en = 1'b0;
                grem--;
            end
            for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom();
            cycle(r, en, d, MW'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
